// File: rtl/jtcop_objdma_if.sv
// rtl/jtcop_objdma_if.sv - CPU-decode, object RAM and object buffer signals around the object DMA
interface jtcop_objdma_if #(
    parameter int AW = 10
);
    logic          LVBL;
    logic          dma_req;
    logic          cpu_cs;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] src_addr;
    logic [15:0]   src_dout;
    logic [AW-1:0] dst_addr;
    logic [15:0]   dst_din;
    logic          dst_we;
    logic          dst_bank;
    logic          busy;
    logic          done;

    modport slave (
        input  LVBL, dma_req, cpu_cs, cpu_addr, src_dout,
        output src_addr, dst_addr, dst_din, dst_we, dst_bank, busy, done
    );

    modport master (
        output LVBL, dma_req, cpu_cs, cpu_addr, src_dout,
        input  src_addr, dst_addr, dst_din, dst_we, dst_bank, busy, done
    );
endinterface

// File: rtl/jtcop_objdma.sv
// rtl/jtcop_objdma.sv - object RAM to object buffer copy sequencer, CPU has read priority
// Optional double-buffered destination bank: JTCOP_OBJDMA_DBUF_EN.
module jtcop_objdma #(
    parameter int AW         = 10,
    parameter bit WAIT_BLANK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    jtcop_objdma_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COPY  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] iss_q, iss_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          rd_vld_q, rd_vld_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic          start_ok;
    logic          last_rd;

    assign start_ok = !WAIT_BLANK || !bus.LVBL;
    assign last_rd  = (cnt_q == {AW{1'b1}});

    // CPU owns the read port whenever it selects object RAM
    assign bus.src_addr = bus.cpu_cs ? bus.cpu_addr : cnt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iss_d    = iss_q;
        rd_vld_d = 1'b0;
        pend_d   = pend_q;
        done_d   = 1'b0;
        we_d     = rd_vld_q;
        waddr_d  = rd_vld_q ? iss_q : waddr_q;
        wdata_d  = rd_vld_q ? bus.src_dout : wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.dma_req) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_d = '0;
                if (bus.dma_req) begin
                    pend_d = 1'b1;
                end
                if (start_ok) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                if (bus.dma_req) begin
                    pend_d = 1'b1;
                end
                if (!bus.cpu_cs) begin
                    iss_d    = cnt_q;
                    cnt_d    = cnt_q + AW'(1);
                    rd_vld_d = 1'b1;
                    // terminal test on the issued address, so the wrap never adds a write
                    if (last_rd) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (done_q) begin
                    pend_d  = 1'b0;
                    state_d = (pend_q || bus.dma_req) ? ST_ARM : ST_IDLE;
                end else begin
                    if (bus.dma_req) begin
                        pend_d = 1'b1;
                    end
                    if (we_q && !rd_vld_q) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            iss_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rd_vld_q <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            iss_q    <= iss_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rd_vld_q <= rd_vld_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign bus.dst_addr = waddr_q;
    assign bus.dst_din  = wdata_q;
    assign bus.dst_we   = we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef JTCOP_OBJDMA_DBUF_EN
    // flip together with done so the renderer sees the finished bank at once
    logic bank_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_q <= 1'b0;
        end else if (done_d) begin
            bank_q <= ~bank_q;
        end
    end

    assign bus.dst_bank = bank_q;
`else
    assign bus.dst_bank = 1'b0;
`endif
endmodule

// File: tb/tb_jtcop_objdma.sv
// tb/tb_jtcop_objdma.sv - self-checking bench for jtcop_objdma
// Copies are predicted from request/stall timelines and compared against recorded writes and pulses.
module tb_jtcop_objdma;
    localparam int AW    = 4;
    localparam int N     = 1 << AW;
    localparam int DEPTH = 4096;
`ifdef JTCOP_OBJDMA_DBUF_EN
    localparam int DBUF = 1;
`else
    localparam int DBUF = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtcop_objdma_if #(.AW(AW)) b0 ();
    jtcop_objdma_if #(.AW(AW)) b1 ();

    jtcop_objdma #(.AW(AW), .WAIT_BLANK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    jtcop_objdma #(.AW(AW), .WAIT_BLANK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [15:0] mem [N];
    always @(posedge clk) begin
        b0.src_dout <= mem[b0.src_addr];
        b1.src_dout <= mem[b1.src_addr];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          req_at [DEPTH];
    bit          cs_at  [DEPTH];
    logic [31:0] wq0 [$];
    logic [31:0] wq1 [$];
    int          we1_edge [$];
    int          dq0 [$];
    int          dq1 [$];
    int          brise0 [$];
    int          bfall0 [$];
    int          exp_done [$];
    int          nd0 = 0;
    int          nd1 = 0;
    int          fix_addr = -1;
    logic        prev_busy0 = 1'b0;
    int          base;
    int          e0;
    int          r1;
    bit          found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst == 1'b0) begin
            nd0 = 0;
            nd1 = 0;
        end
        if (b0.dst_we === 1'b1) wq0.push_back(32'({b0.dst_addr, b0.dst_din}));
        if (b1.dst_we === 1'b1) begin
            wq1.push_back(32'({b1.dst_addr, b1.dst_din}));
            we1_edge.push_back(cyc);
        end
        if (b0.done === 1'b1) begin
            dq0.push_back(cyc);
            nd0++;
        end
        if (b1.done === 1'b1) begin
            dq1.push_back(cyc);
            nd1++;
        end
        if (b0.busy === 1'b1 && prev_busy0 === 1'b0) brise0.push_back(cyc);
        if (b0.busy === 1'b0 && prev_busy0 === 1'b1) bfall0.push_back(cyc);
        prev_busy0 = b0.busy;
        chk("bank0", 32'(b0.dst_bank), 32'(DBUF * (nd0 % 2)));
        chk("bank1", 32'(b1.dst_bank), 32'(DBUF * (nd1 % 2)));
    endtask

    task automatic run(input int ncyc);
        logic [AW-1:0] a;
        for (int k = 0; k < ncyc; k++) begin
            a = (fix_addr >= 0) ? AW'(fix_addr) : AW'($urandom);
            b0.dma_req  = req_at[cyc + 1];
            b0.cpu_cs   = cs_at[cyc + 1];
            b0.cpu_addr = a;
            #1;
            if (b0.cpu_cs) chk("src_addr_cpu", 32'(b0.src_addr), 32'(a));
            step();
        end
        b0.dma_req = 1'b0;
        b0.cpu_cs  = 1'b0;
    endtask

    // A request seen at edge r reaches COPY at r+1; reads issue on non-stalled edges from r+2;
    // done follows the last issue by two edges; requests up to the edge after done chain a copy.
    task automatic model(input int from);
        int r;
        int e;
        int left;
        int d;
        bit pend;
        exp_done.delete();
        r = -1;
        for (int i = from; i < DEPTH; i++) if (req_at[i]) begin r = i; break; end
        while (r >= 0) begin
            left = N;
            e    = r + 2;
            while (left > 0 && e < DEPTH) begin
                if (!cs_at[e]) left--;
                e++;
            end
            d = (e - 1) + 2;
            exp_done.push_back(d);
            pend = 1'b0;
            for (int i = r + 1; i <= d + 1 && i < DEPTH; i++) if (req_at[i]) pend = 1'b1;
            if (pend) begin
                r = d + 1;
            end else begin
                r = -1;
                for (int i = d + 2; i < DEPTH; i++) if (req_at[i]) begin r = i; break; end
            end
        end
    endtask

    task automatic clear0();
        wq0.delete();
        dq0.delete();
        brise0.delete();
        bfall0.delete();
    endtask

    task automatic check_run(input string tag, input int from);
        int nw;
        model(from);
        chk({tag, "_ndone"}, 32'(dq0.size()), 32'(exp_done.size()));
        for (int i = 0; i < dq0.size() && i < exp_done.size(); i++)
            chk({tag, "_done_edge"}, 32'(dq0[i]), 32'(exp_done[i]));
        nw = N * exp_done.size();
        chk({tag, "_nwrites"}, 32'(wq0.size()), 32'(nw));
        for (int i = 0; i < wq0.size() && i < nw; i++)
            chk({tag, "_write"}, wq0[i], 32'({AW'(i % N), mem[i % N]}));
        if (exp_done.size() > 0 && bfall0.size() > 0)
            chk({tag, "_busy_fall"}, 32'(bfall0[bfall0.size() - 1]), 32'(exp_done[exp_done.size() - 1] + 1));
        chk({tag, "_busy_idle"}, 32'(b0.busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        rst         = 1'b0;
        b0.LVBL     = 1'b1;
        b0.dma_req  = 1'b0;
        b0.cpu_cs   = 1'b0;
        b0.cpu_addr = '0;
        b1.LVBL     = 1'b1;
        b1.dma_req  = 1'b0;
        b1.cpu_cs   = 1'b0;
        b1.cpu_addr = '0;
        for (int i = 0; i < N; i++) mem[i] = 16'(i * 3);
        repeat (3) step();

        chk("rst_busy0",  32'(b0.busy),     32'(0));
        chk("rst_done0",  32'(b0.done),     32'(0));
        chk("rst_we0",    32'(b0.dst_we),   32'(0));
        chk("rst_addr0",  32'(b0.dst_addr), 32'(0));
        chk("rst_din0",   32'(b0.dst_din),  32'(0));
        chk("rst_bank0",  32'(b0.dst_bank), 32'(0));
        chk("rst_busy1",  32'(b1.busy),     32'(0));
        chk("rst_done1",  32'(b1.done),     32'(0));
        chk("rst_we1",    32'(b1.dst_we),   32'(0));
        chk("rst_addr1",  32'(b1.dst_addr), 32'(0));
        chk("rst_din1",   32'(b1.dst_din),  32'(0));
        chk("rst_bank1",  32'(b1.dst_bank), 32'(0));
        rst = 1'b1;

        // single unstalled copy, data = address*3
        clear0();
        base = cyc;
        req_at[base + 3] = 1'b1;
        run(30);
        check_run("unstalled", base + 1);
        chk("unstalled_latency", 32'(dq0.size() > 0 ? dq0[0] : -1), 32'(base + 3 + 1 + 18));
        chk("busy_rise", 32'(brise0.size() > 0 ? brise0[0] : -1), 32'(base + 3));

        // three CPU stall cycles mid-copy at cpu_addr 7
        clear0();
        base = cyc;
        req_at[base + 3] = 1'b1;
        for (int k = 0; k < 3; k++) cs_at[base + 3 + 6 + k] = 1'b1;
        fix_addr = 7;
        run(35);
        fix_addr = -1;
        check_run("stall3", base + 1);
        chk("stall3_latency", 32'(dq0.size() > 0 ? dq0[0] : -1), 32'(base + 3 + 1 + 18 + 3));

        // extra requests during a copy merge into one back-to-back copy
        clear0();
        base = cyc;
        req_at[base + 3]  = 1'b1;
        req_at[base + 8]  = 1'b1;
        req_at[base + 12] = 1'b1;
        run(60);
        check_run("pending", base + 1);
        chk("pending_two_done", 32'(dq0.size()), 32'(2));
        chk("pending_gap", 32'(dq0.size() > 1 ? dq0[1] - dq0[0] : -1), 32'(20));

        // random data, random stalls and random extra requests
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
            clear0();
            base = cyc;
            req_at[base + 2] = 1'b1;
            for (int e = base + 3; e <= base + 30; e++) if ($urandom_range(0, 7) == 0) req_at[e] = 1'b1;
            for (int e = base + 2; e < base + 110; e++) cs_at[e] = ($urandom_range(0, 3) == 0);
            run(120);
            check_run("random", base + 1);
        end

        // reset while word 5 is being written
        clear0();
        found = 1'b0;
        b0.dma_req = 1'b1;
        step();
        b0.dma_req = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (b0.dst_we === 1'b1 && b0.dst_addr === AW'(5)) found = 1'b1;
        end
        chk("abort_reached_word5", 32'(found), 32'(1));
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_we",   32'(b0.dst_we), 32'(0));
        chk("abort_busy", 32'(b0.busy),   32'(0));
        chk("abort_done", 32'(b0.done),   32'(0));
        wq0.delete();
        run(10);
        chk("abort_quiet", 32'(wq0.size()), 32'(0));
        clear0();
        base = cyc;
        req_at[base + 2] = 1'b1;
        run(30);
        check_run("after_abort", base + 1);

        // blank-gated instance: hold off until LVBL falls, keep going after it rises
        wq1.delete();
        we1_edge.delete();
        dq1.delete();
        b1.LVBL    = 1'b1;
        b1.dma_req = 1'b1;
        step();
        b1.dma_req = 1'b0;
        repeat (8) step();
        chk("wb_busy_waiting", 32'(b1.busy),    32'(1));
        chk("wb_no_we",        32'(wq1.size()), 32'(0));
        b1.LVBL = 1'b0;
        e0 = cyc + 1;
        repeat (3) step();
        b1.LVBL = 1'b1;
        repeat (30) step();
        chk("wb_nwrites",    32'(wq1.size()), 32'(N));
        chk("wb_first_we",   32'(we1_edge.size() > 0 ? we1_edge[0] : -1), 32'(e0 + 2));
        chk("wb_done_edge",  32'(dq1.size() > 0 ? dq1[0] : -1), 32'(e0 + 18));
        for (int i = 0; i < wq1.size() && i < N; i++)
            chk("wb_write", wq1[i], 32'({AW'(i), mem[i]}));
        chk("wb_busy_idle", 32'(b1.busy), 32'(0));

        // LVBL already low when the request arrives
        dq1.delete();
        b1.LVBL    = 1'b0;
        b1.dma_req = 1'b1;
        step();
        r1 = cyc;
        b1.dma_req = 1'b0;
        repeat (25) step();
        chk("wb_low_done", 32'(dq1.size() > 0 ? dq1[0] : -1), 32'(r1 + 19));
        chk("wb_low_ndone", 32'(dq1.size()), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
